// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Target end of the core's data-memory load/store channel. The memory is
// word addressed and written one byte lane at a time. Stores commit on the
// accepting clock edge and return nothing. Loads read the memory synchronously,
// pass LATENCY-1 further register stages and then reach a small response queue
// that absorbs consumer backpressure.
//
// Flow control is credit based. 'Outstanding' counts every accepted load that
// has not yet completed its response handshake, whether it is still in the
// pipeline or already queued. New requests, stores included, are accepted only
// while that count is below RSP_DEPTH. As a result the queue can never
// overflow, and stores can never overtake loads that are waiting for credit.
//
// Ports
//   clk        clock
//   rst        synchronous, active-high reset
//   req_valid  request valid                   (from core LSU)
//   req_ready  request accepted when valid && ready
//   req_we     1 = store, 0 = load
//   req_addr   word address, $clog2(MEM_SIZE_W) bits
//   req_wmask  store byte enables, bit i -> byte i
//   req_wdata  store data, byte-lane aligned
//   rsp_valid  load data valid                 (to core writeback)
//   rsp_ready  consumer ready
//   rsp_data   full 32-bit load word
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int MEM_SIZE_W = 16384,
    parameter int LATENCY    = 1,
    parameter int RSP_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [$clog2(MEM_SIZE_W)-1:0] req_addr,
    input  logic [3:0]                    req_wmask,
    input  logic [31:0]                   req_wdata,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_data
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int LAST  = LATENCY - 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(RSP_DEPTH);
    localparam logic [PTR_W-1:0] PTR_MAX_C = PTR_W'(RSP_DEPTH - 1);

    // Storage and state
    logic [31:0]        mem_r [MEM_SIZE_W];
    logic [CNT_W-1:0]   outstanding_r;
    logic [LATENCY-1:0] pipe_v_r;
    logic [31:0]        pipe_d_r [LATENCY];
    logic [31:0]        q_mem_r [RSP_DEPTH];
    logic [PTR_W-1:0]   q_head_r;
    logic [PTR_W-1:0]   q_tail_r;
    logic [CNT_W-1:0]   q_count_r;

    // Handshake decode
    logic req_fire_s;
    logic load_fire_s;
    logic store_fire_s;
    logic rsp_fire_s;
    logic q_empty_s;
    logic pipe_out_v_s;
    logic push_s;
    logic pop_s;

    // Circular pointer advance that also works for non-power-of-two depths.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_MAX_C) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // The credit check uses registered state only. The rst term keeps the port
    // closed during the reset cycle, so a store presented there cannot commit.
    assign req_ready    = !rst && (outstanding_r < DEPTH_C);
    assign req_fire_s   = req_valid && req_ready;
    assign load_fire_s  = req_fire_s && !req_we;
    assign store_fire_s = req_fire_s && req_we;
    assign rsp_fire_s   = rsp_valid && rsp_ready;

    assign q_empty_s    = (q_count_r == {CNT_W{1'b0}});
    assign pipe_out_v_s = pipe_v_r[LAST];

    // When the queue is empty and the consumer takes the word in the cycle it
    // arrives, the word bypasses the queue. Otherwise it is appended, which
    // keeps responses in acceptance order.
    assign push_s = pipe_out_v_s && !(rsp_fire_s && q_empty_s);
    assign pop_s  = rsp_fire_s && !q_empty_s;

    // Response port: the queue head has priority. The pipeline output is only
    // shown when nothing older is waiting.
    always_comb begin
        rsp_valid = !rst && (!q_empty_s || pipe_out_v_s);
        if (q_empty_s) begin
            rsp_data = pipe_d_r[LAST];
        end else begin
            rsp_data = q_mem_r[q_head_r];
        end
    end

    // Byte-enabled store commit. Memory contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (store_fire_s) begin
            for (int i = 0; i < 4; i++) begin
                if (req_wmask[i]) begin
                    mem_r[req_addr][8*i +: 8] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    // Synchronous read into stage 0, followed by LATENCY-1 delay stages.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v_r <= {LATENCY{1'b0}};
            for (int i = 0; i < LATENCY; i++) begin
                pipe_d_r[i] <= 32'h0000_0000;
            end
        end else begin
            pipe_v_r[0] <= load_fire_s;
            if (load_fire_s) begin
                pipe_d_r[0] <= mem_r[req_addr];
            end
            for (int i = 1; i < LATENCY; i++) begin
                pipe_v_r[i] <= pipe_v_r[i-1];
                pipe_d_r[i] <= pipe_d_r[i-1];
            end
        end
    end

    // Response queue. Credit guarantees that a push never finds it full.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_head_r  <= {PTR_W{1'b0}};
            q_tail_r  <= {PTR_W{1'b0}};
            q_count_r <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                q_mem_r[q_tail_r] <= pipe_d_r[LAST];
                q_tail_r          <= ptr_inc(q_tail_r);
            end
            if (pop_s) begin
                q_head_r <= ptr_inc(q_head_r);
            end
            case ({push_s, pop_s})
                2'b10:   q_count_r <= q_count_r + CNT_W'(1);
                2'b01:   q_count_r <= q_count_r - CNT_W'(1);
                default: q_count_r <= q_count_r;
            endcase
        end
    end

    // Credit counter: +1 per accepted load, -1 per response handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding_r <= {CNT_W{1'b0}};
        end else begin
            case ({load_fire_s, rsp_fire_s})
                2'b10:   outstanding_r <= outstanding_r + CNT_W'(1);
                2'b01:   outstanding_r <= outstanding_r - CNT_W'(1);
                default: outstanding_r <= outstanding_r;
            endcase
        end
    end

endmodule
